// File: rtl/pwm_cmd_shaper.sv
// pwm_cmd_shaper
//   Per-axis command conditioner between the SPI slave command register and
//   the steering PWM stage. Resynchronises the SPI-domain toggle, clamps the
//   signed command to +/-MAX_MAG, slew-limits the output by STEP per prescaler
//   tick, forces a zero-hold deadtime before any sign reversal, and ramps to
//   zero when the host stops sending commands.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active high
//   cmd_in      signed target from the SPI slave (stable around toggle edges)
//   cmd_toggle  SPI-domain toggle, each level change marks a new cmd_in
//   cmd_out     signed shaped command to the steering stage
//   at_target   cmd_out equals target and the shaper is in RUN
//   zero_hold   high while the reversal deadtime is running
//   wdt_expired command watchdog tripped; cleared by the next command
module pwm_cmd_shaper #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_MAG    = 2047,
  parameter int STEP       = 16,
  parameter int STEP_DIV   = 1000,
  parameter int DEADTIME   = 50_000,
  parameter int WDT_CYCLES = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] cmd_in,
  input  logic                         cmd_toggle,
  output logic signed [DATA_WIDTH-1:0] cmd_out,
  output logic                         at_target,
  output logic                         zero_hold,
  output logic                         wdt_expired
);

  localparam int XW = DATA_WIDTH + 1;
  localparam int PW = $clog2(STEP_DIV + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam int WW = $clog2(WDT_CYCLES + 1);

  localparam logic [PW-1:0] PSC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DT_LAST  = DW'(DEADTIME - 1);
  localparam logic [WW-1:0] WDT_TRIP = WW'(WDT_CYCLES - 2);
  localparam logic [WW-1:0] WDT_SAT  = WW'(WDT_CYCLES - 1);

  localparam logic signed [DATA_WIDTH-1:0] MAX_D  = DATA_WIDTH'(MAX_MAG);
  localparam logic signed [DATA_WIDTH-1:0] NEG_D  = DATA_WIDTH'(-MAX_MAG);
  localparam logic signed [DATA_WIDTH-1:0] STEP_D = DATA_WIDTH'(STEP);
  localparam logic signed [XW-1:0]         STEP_X = XW'(STEP);

  typedef enum logic {RUN, HOLD} state_t;

  state_t                         state;
  logic                           s1, s2, s3;
  logic [PW-1:0]                  psc;
  logic [DW-1:0]                  dt_cnt;
  logic [WW-1:0]                  wdt_cnt;
  logic signed [DATA_WIDTH-1:0]   target;

  logic                           tog_edge;
  logic                           tick;
  logic signed [DATA_WIDTH-1:0]   clamp_val;
  logic signed [XW-1:0]           out_x, tgt_x, diff, diff_mag;
  logic signed [DATA_WIDTH-1:0]   out_mag;
  logic                           reversal;
  logic signed [DATA_WIDTH-1:0]   run_next;
  logic                           run_hold;

  assign tog_edge  = s2 ^ s3;
  assign tick      = (psc == PSC_LAST);
  assign at_target = (state == RUN) && (cmd_out == target);

  // Clamp compares in DATA_WIDTH: the bounds are representable, so no
  // widening is needed for the comparison itself.
  assign clamp_val = (cmd_in > MAX_D) ? MAX_D :
                     (cmd_in < NEG_D) ? NEG_D : cmd_in;

  // target - cmd_out can span 2*MAX_MAG, so take it one bit wider.
  assign out_x    = {cmd_out[DATA_WIDTH-1], cmd_out};
  assign tgt_x    = {target[DATA_WIDTH-1], target};
  assign diff     = tgt_x - out_x;
  assign diff_mag = diff[XW-1] ? -diff : diff;
  assign out_mag  = cmd_out[DATA_WIDTH-1] ? -cmd_out : cmd_out;

  // A zero target is never a reversal: decaying to zero needs no deadtime.
  assign reversal = (cmd_out != '0) && (target != '0) &&
                    (cmd_out[DATA_WIDTH-1] != target[DATA_WIDTH-1]);

  // Output value for a tick in RUN. During a reversal the output is walked
  // to zero first, and the final step into zero arms the deadtime.
  always_comb begin
    run_next = cmd_out;
    run_hold = 1'b0;
    if (reversal) begin
      if (out_mag <= STEP_D) begin
        run_next = '0;
        run_hold = 1'b1;
      end else begin
        run_next = cmd_out[DATA_WIDTH-1] ? cmd_out + STEP_D : cmd_out - STEP_D;
      end
    end else if (diff_mag <= STEP_X) begin
      run_next = target;
    end else begin
      run_next = diff[XW-1] ? cmd_out - STEP_D : cmd_out + STEP_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cmd_out     <= '0;
      target      <= '0;
      psc         <= '0;
      dt_cnt      <= '0;
      wdt_cnt     <= '0;
      zero_hold   <= 1'b0;
      wdt_expired <= 1'b0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
    end else begin
      s1 <= cmd_toggle;
      s2 <= s1;
      s3 <= s2;

      psc <= tick ? '0 : psc + 1'b1;

      // A fresh command always beats a watchdog trip in the same cycle.
      if (tog_edge) begin
        target      <= clamp_val;
        wdt_cnt     <= '0;
        wdt_expired <= 1'b0;
      end else begin
        if (wdt_cnt != WDT_SAT) wdt_cnt <= wdt_cnt + 1'b1;
        if (wdt_cnt == WDT_TRIP) begin
          wdt_expired <= 1'b1;
          target      <= '0;
        end
      end

      case (state)
        RUN: begin
          if (tick) begin
            cmd_out <= run_next;
            if (run_hold) begin
              state     <= HOLD;
              zero_hold <= 1'b1;
              dt_cnt    <= '0;
            end
          end
        end
        HOLD: begin
          // Fixed-length hold; target changes meanwhile are only latched.
          if (dt_cnt == DT_LAST) begin
            state     <= RUN;
            zero_hold <= 1'b0;
          end else begin
            dt_cnt <= dt_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cmd_shaper.sv
// Directed bench for pwm_cmd_shaper with STEP_DIV=4, STEP=100, DEADTIME=8,
// WDT_CYCLES=200, MAX_MAG=2047. A bench-side cycle counter, cleared by the
// same reset as the prescaler, marks where the step ticks land, so every
// expected ramp value below is a hand-computed constant.
module tb_pwm_cmd_shaper;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] cmd_in = '0;
  logic                 cmd_toggle = 1'b0;
  logic signed [DW-1:0] cmd_out;
  logic                 at_target;
  logic                 zero_hold;
  logic                 wdt_expired;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_tog  = 0;

  pwm_cmd_shaper #(
    .DATA_WIDTH (DW),
    .MAX_MAG    (2047),
    .STEP       (100),
    .STEP_DIV   (4),
    .DEADTIME   (8),
    .WDT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_in      (cmd_in),
    .cmd_toggle  (cmd_toggle),
    .cmd_out     (cmd_out),
    .at_target   (at_target),
    .zero_hold   (zero_hold),
    .wdt_expired (wdt_expired)
  );

  always #5 clk = ~clk;

  // Edges since reset; a tick lands on every edge where this becomes a
  // nonzero multiple of 4.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge just after the next tick edge.
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % 4) != 0 && n < 8);
  endtask

  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // cmd_in settles 3 clk before the toggle flips; t_tog records the flip.
  task automatic send_cmd(input int v);
    cmd_in = v[DW-1:0];
    clk_n(3);
    cmd_toggle = ~cmd_toggle;
    t_tog = cyc;
  endtask

  initial begin
    int c1;
    int n;

    // Reset state
    rst = 1'b1;
    clk_n(3);
    chk("rst_cmd_out", 32'(cmd_out), 0);
    chk("rst_zero_hold", 32'(zero_hold), 0);
    chk("rst_wdt", 32'(wdt_expired), 0);
    chk("rst_at_target", 32'(at_target), 1);
    rst = 1'b0;

    // Ramp 0 -> 1000 with 3-clk capture latency
    send_cmd(1000);
    clk_n(2);
    chk("tgt_before_latency", 32'(dut.target), 0);
    clk_n(1);
    chk("tgt_after_latency", 32'(dut.target), 1000);
    for (int i = 1; i <= 10; i++) begin
      next_tick();
      chk("ramp_up", 32'(cmd_out), 100 * i);
      if (i == 9) chk("ramp_not_at_target", 32'(at_target), 0);
    end
    chk("ramp_at_target", 32'(at_target), 1);

    // Reversal 1000 -> -500 through an 8-clk zero hold
    send_cmd(-500);
    clk_n(3);
    for (int i = 1; i <= 10; i++) begin
      next_tick();
      chk("rev_down", 32'(cmd_out), 1000 - 100 * i);
    end
    for (int i = 0; i < 8; i++) begin
      chk("hold_zero_hold", 32'(zero_hold), 1);
      chk("hold_cmd_out", 32'(cmd_out), 0);
      @(negedge clk);
    end
    chk("hold_end_zero_hold", 32'(zero_hold), 0);
    chk("hold_end_cmd_out", 32'(cmd_out), 0);
    for (int i = 1; i <= 5; i++) begin
      next_tick();
      chk("rev_neg_ramp", 32'(cmd_out), -100 * i);
    end
    chk("rev_at_target", 32'(at_target), 1);

    // Decay to zero target: no hold
    send_cmd(0);
    clk_n(3);
    for (int i = 1; i <= 5; i++) begin
      next_tick();
      chk("decay_zero", 32'(cmd_out), -500 + 100 * i);
    end
    chk("decay_no_hold", 32'(zero_hold), 0);

    // Clamp -32768 -> -2047, last step -47
    send_cmd(-32768);
    clk_n(3);
    chk("clamp_target", 32'(dut.target), -2047);
    for (int i = 1; i <= 21; i++) begin
      next_tick();
      chk("clamp_ramp", 32'(cmd_out), (i <= 20) ? -100 * i : -2047);
    end
    chk("clamp_no_hold", 32'(zero_hold), 0);
    chk("clamp_at_target", 32'(at_target), 1);

    // Back to zero before the watchdog case
    send_cmd(0);
    clk_n(3);
    repeat (21) next_tick();
    chk("return_zero", 32'(cmd_out), 0);
    chk("return_no_hold", 32'(zero_hold), 0);

    // Watchdog: settle at 300, then no toggles
    send_cmd(300);
    clk_n(3);
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      chk("wdt_ramp_up", 32'(cmd_out), 100 * i);
    end
    wait_cyc(t_tog + 201);
    chk("wdt_not_yet", 32'(wdt_expired), 0);
    clk_n(1);
    chk("wdt_tripped", 32'(wdt_expired), 1);
    chk("wdt_target_zero", 32'(dut.target), 0);
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      chk("wdt_ramp_down", 32'(cmd_out), 300 - 100 * i);
    end
    chk("wdt_no_hold", 32'(zero_hold), 0);

    // New command clears the flag 3 clk after its toggle
    send_cmd(400);
    c1 = t_tog;
    clk_n(2);
    chk("wdt_still_set", 32'(wdt_expired), 1);
    clk_n(1);
    chk("wdt_cleared", 32'(wdt_expired), 0);
    for (int i = 1; i <= 4; i++) begin
      next_tick();
      chk("wdt_recover_ramp", 32'(cmd_out), 100 * i);
    end

    // Toggle edge lands on the watchdog expiry cycle
    cmd_in = 16'sd600;
    wait_cyc(c1 + 199);
    cmd_toggle = ~cmd_toggle;
    wait_cyc(c1 + 201);
    chk("sim_wdt_pre", 32'(wdt_expired), 0);
    clk_n(1);
    chk("sim_wdt", 32'(wdt_expired), 0);
    chk("sim_target", 32'(dut.target), 600);
    next_tick();
    chk("sim_ramp_1", 32'(cmd_out), 500);
    next_tick();
    chk("sim_ramp_2", 32'(cmd_out), 600);
    chk("sim_at_target", 32'(at_target), 1);

    // Reset mid-ramp; toggle is high at release so 1500 is recaptured
    send_cmd(1500);
    clk_n(3);
    next_tick();
    chk("midramp_1", 32'(cmd_out), 700);
    next_tick();
    chk("midramp_2", 32'(cmd_out), 800);
    rst = 1'b1;
    clk_n(1);
    chk("rst_ramp_cmd_out", 32'(cmd_out), 0);
    chk("rst_ramp_zero_hold", 32'(zero_hold), 0);
    chk("rst_ramp_wdt", 32'(wdt_expired), 0);
    chk("rst_ramp_at_target", 32'(at_target), 1);
    rst = 1'b0;
    clk_n(2);
    chk("recap_pre", 32'(dut.target), 0);
    clk_n(1);
    chk("recap_target", 32'(dut.target), 1500);
    next_tick();
    chk("recap_ramp_1", 32'(cmd_out), 100);
    next_tick();
    chk("recap_ramp_2", 32'(cmd_out), 200);

    // Reset during HOLD
    send_cmd(-100);
    clk_n(3);
    n = 0;
    while (!zero_hold && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_entered", 32'(zero_hold), 1);
    chk("hold_entry_out", 32'(cmd_out), 0);
    clk_n(3);
    chk("hold_mid", 32'(zero_hold), 1);
    rst = 1'b1;
    clk_n(1);
    chk("rst_hold_zero_hold", 32'(zero_hold), 0);
    chk("rst_hold_cmd_out", 32'(cmd_out), 0);
    chk("rst_hold_at_target", 32'(at_target), 1);
    rst = 1'b0;
    send_cmd(250);
    clk_n(3);
    next_tick();
    chk("post_rst_1", 32'(cmd_out), 100);
    next_tick();
    chk("post_rst_2", 32'(cmd_out), 200);
    next_tick();
    chk("post_rst_3", 32'(cmd_out), 250);
    chk("post_rst_at_target", 32'(at_target), 1);
    chk("post_rst_no_hold", 32'(zero_hold), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
